// File: rtl/encoder_position_tracker.sv
// Position/velocity tracker fed by a quadrature decoder's per-clock dir code.
// Latency: one register stage; dir sampled at an edge is reflected after that edge.
// No backpressure: a dir code is consumed every cycle.
module encoder_position_tracker #(
  parameter int POS_WIDTH     = 16,
  parameter int VEL_WIDTH     = 12,
  parameter int WINDOW_CYCLES = 1000,
  parameter bit SATURATE      = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  dir,
  input  logic                        clear,
  input  logic                        load,
  input  logic signed [POS_WIDTH-1:0] load_value,
  output logic signed [POS_WIDTH-1:0] position,
  output logic signed [VEL_WIDTH-1:0] velocity,
  output logic                        vel_valid,
  output logic [1:0]                  last_dir,
  output logic                        moving,
  output logic                        sat_flag,
  output logic                        dir_err
);

  localparam int CW = $clog2(WINDOW_CYCLES);
  localparam logic [CW-1:0] WIN_LAST = CW'(WINDOW_CYCLES - 1);
  localparam logic signed [POS_WIDTH-1:0] POS_MAX = {1'b0, {(POS_WIDTH-1){1'b1}}};
  localparam logic signed [POS_WIDTH-1:0] POS_MIN = {1'b1, {(POS_WIDTH-1){1'b0}}};
  localparam logic signed [VEL_WIDTH-1:0] VEL_MAX = {1'b0, {(VEL_WIDTH-1){1'b1}}};
  localparam logic signed [VEL_WIDTH-1:0] VEL_MIN = {1'b1, {(VEL_WIDTH-1){1'b0}}};

  logic                        step_up;
  logic                        step_dn;
  logic                        win_end;
  logic [CW-1:0]               win_cnt;
  logic signed [VEL_WIDTH-1:0] acc;
  logic signed [VEL_WIDTH-1:0] acc_sum;
  logic signed [POS_WIDTH-1:0] pos_step;
  logic                        pos_clamp;

  assign step_up = (dir == 2'b01);
  assign step_dn = (dir == 2'b10);
  assign win_end = (win_cnt == WIN_LAST);

  // Next position from the step alone, clamping or wrapping at the limits.
  always_comb begin
    pos_step  = position;
    pos_clamp = 1'b0;
    if (step_up) begin
      if (SATURATE && position == POS_MAX) pos_clamp = 1'b1;
      else                                 pos_step  = position + POS_WIDTH'(1);
    end else if (step_dn) begin
      if (SATURATE && position == POS_MIN) pos_clamp = 1'b1;
      else                                 pos_step  = position - POS_WIDTH'(1);
    end
  end

  // Window accumulator plus this cycle's step, held at the signed limits.
  always_comb begin
    acc_sum = acc;
    if (step_up && acc != VEL_MAX)      acc_sum = acc + VEL_WIDTH'(1);
    else if (step_dn && acc != VEL_MIN) acc_sum = acc - VEL_WIDTH'(1);
  end

  // Position register: clear beats load, load beats the step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     position <= '0;
    else if (clear) position <= '0;
    else if (load)  position <= load_value;
    else            position <= pos_step;
  end

  // Sticky flags and last legal direction; a clamp under load never happened.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag <= 1'b0;
      dir_err  <= 1'b0;
      last_dir <= 2'b00;
    end else if (clear) begin
      sat_flag <= 1'b0;
      dir_err  <= 1'b0;
      last_dir <= 2'b00;
    end else begin
      if (!load && pos_clamp)  sat_flag <= 1'b1;
      if (dir == 2'b11)        dir_err  <= 1'b1;
      if (step_up || step_dn)  last_dir <= dir;
    end
  end

  // Free-running velocity window; publishes net steps on the window's last cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt   <= '0;
      acc       <= '0;
      velocity  <= '0;
      vel_valid <= 1'b0;
      moving    <= 1'b0;
    end else if (clear) begin
      win_cnt   <= '0;
      acc       <= '0;
      velocity  <= '0;
      vel_valid <= 1'b0;
      moving    <= 1'b0;
    end else begin
      vel_valid <= win_end;
      if (win_end) begin
        win_cnt  <= '0;
        acc      <= '0;
        velocity <= acc_sum;
        moving   <= (acc_sum != '0);
      end else begin
        win_cnt  <= win_cnt + CW'(1);
        acc      <= acc_sum;
      end
    end
  end

endmodule
